// File: rtl/awb_pkg.sv
// Shared constants for the AWB gain controller: 8.8 gain format and FSM state encoding.
package awb_pkg;

    localparam int unsigned GAIN_W    = 16;
    localparam int unsigned GAIN_FRAC = 8;
    localparam logic [GAIN_W-1:0] GAIN_UNITY = 16'h0100;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DIV_R = 3'd1;
    localparam logic [2:0] ST_DIV_B = 3'd2;
    localparam logic [2:0] ST_CLAMP = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; done pulses N_W cycles after start.
// A zero divisor naturally yields an all-ones quotient.
module seq_divider #(
    parameter int unsigned N_W = 34,
    parameter int unsigned D_W = 26
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [N_W-1:0] quotient
);

    localparam int unsigned CNT_W = $clog2(N_W + 1);

    logic             busy;
    logic [CNT_W-1:0] count;
    logic [D_W-1:0]   rem;
    logic [D_W-1:0]   dvsr;
    logic [D_W:0]     trial;
    logic             fits;

    // Quotient register doubles as the dividend shifter: MSB feeds the remainder.
    always_comb begin
        trial = {rem, quotient[N_W-1]};
        fits  = (trial >= {1'b0, dvsr});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            count    <= '0;
            rem      <= '0;
            dvsr     <= '0;
            quotient <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                busy     <= 1'b1;
                count    <= CNT_W'(N_W);
                rem      <= '0;
                dvsr     <= divisor;
                quotient <= dividend;
            end else if (busy) begin
                rem      <= fits ? D_W'(trial - {1'b0, dvsr}) : trial[D_W-1:0];
                quotient <= {quotient[N_W-2:0], fits};
                count    <= count - 1'b1;
                if (count == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/awb_gain_ctrl.sv
// Per-frame gray-world AWB gain controller: accumulates RGB sums, divides during blanking,
// and commits clamped 8.8 gains only at frame start.
module awb_gain_ctrl
    import awb_pkg::*;
#(
    parameter int unsigned source_h = 512,
    parameter int unsigned source_v = 512,
    parameter int unsigned SUM_W    = 26,
    parameter logic [15:0] MAX_GAIN = 16'h0400
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_vsync,
    input  logic              in_den,
    input  logic [7:0]        in_data_R,
    input  logic [7:0]        in_data_G,
    input  logic [7:0]        in_data_B,
    input  logic              cfg_enable,
    input  logic              cfg_manual,
    input  logic [GAIN_W-1:0] cfg_gain_R,
    input  logic [GAIN_W-1:0] cfg_gain_B,
    output logic [GAIN_W-1:0] gain_R,
    output logic [GAIN_W-1:0] gain_B,
    output logic              gain_update,
    output logic              busy,
    output logic              overrun
);

    localparam int unsigned N_W = SUM_W + GAIN_FRAC;
    localparam longint MAX_SUM = longint'(source_h) * longint'(source_v) * 255;

    if (MAX_SUM >= (longint'(1) << SUM_W)) begin : g_sum_w_too_small
        $error("SUM_W too small for source_h*source_v*255");
    end

    logic                 vsync_q;
    logic [SUM_W-1:0]     acc_r, acc_g, acc_b;
    logic [SUM_W-1:0]     op_r, op_g, op_b;
    logic [2:0]           state;
    logic [GAIN_W-1:0]    gain_r_tmp, shadow_r, shadow_b;
    logic                 pending;
    logic                 frame_end, frame_start, idle, commit;
    logic                 div_start, div_done;
    logic [N_W-1:0]       div_dividend, div_quotient;
    logic [SUM_W-1:0]     div_divisor;
    logic [GAIN_W-1:0]    next_r, next_b;
    logic                 take_shadow;

    function automatic logic [GAIN_W-1:0] clamp_gain(input logic [N_W-1:0] q,
                                                     input logic zero_div);
        if (zero_div || (q > N_W'(MAX_GAIN))) return MAX_GAIN;
        return q[GAIN_W-1:0];
    endfunction

    assign frame_end   = vsync_q & ~in_vsync;
    assign frame_start = in_vsync & ~vsync_q;
    assign idle        = (state == ST_IDLE);
    assign busy        = ~idle;
    assign commit      = frame_start & idle;

    // Red divide starts straight from the accumulators on the frame-end cycle.
    always_comb begin
        div_start    = 1'b0;
        div_dividend = {op_g, {GAIN_FRAC{1'b0}}};
        div_divisor  = op_b;
        if (idle && frame_end) begin
            div_start    = 1'b1;
            div_dividend = {acc_g, {GAIN_FRAC{1'b0}}};
            div_divisor  = acc_r;
        end else if (state == ST_DIV_R && div_done) begin
            div_start = 1'b1;
        end
    end

    seq_divider #(
        .N_W(N_W),
        .D_W(SUM_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .start   (div_start),
        .dividend(div_dividend),
        .divisor (div_divisor),
        .done    (div_done),
        .quotient(div_quotient)
    );

    always_comb begin
        next_r      = gain_R;
        next_b      = gain_B;
        take_shadow = 1'b0;
        if (cfg_manual) begin
            next_r = cfg_gain_R;
            next_b = cfg_gain_B;
        end else if (!cfg_enable) begin
            next_r = GAIN_UNITY;
            next_b = GAIN_UNITY;
        end else if (pending) begin
            next_r      = shadow_r;
            next_b      = shadow_b;
            take_shadow = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q    <= 1'b0;
            acc_r      <= '0;
            acc_g      <= '0;
            acc_b      <= '0;
            op_r       <= '0;
            op_g       <= '0;
            op_b       <= '0;
            state      <= ST_IDLE;
            gain_r_tmp <= GAIN_UNITY;
            shadow_r   <= GAIN_UNITY;
            shadow_b   <= GAIN_UNITY;
            pending    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            vsync_q <= in_vsync;
            if (frame_end) begin
                acc_r <= '0;
                acc_g <= '0;
                acc_b <= '0;
            end else if (in_vsync && in_den) begin
                acc_r <= acc_r + SUM_W'(in_data_R);
                acc_g <= acc_g + SUM_W'(in_data_G);
                acc_b <= acc_b + SUM_W'(in_data_B);
            end

            // A frame end while busy drops that frame's statistics.
            if (frame_end) begin
                if (idle) begin
                    op_r  <= acc_r;
                    op_g  <= acc_g;
                    op_b  <= acc_b;
                    state <= ST_DIV_R;
                end else begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                ST_DIV_R: if (div_done) begin
                    gain_r_tmp <= clamp_gain(div_quotient, op_r == '0);
                    state      <= ST_DIV_B;
                end
                ST_DIV_B: if (div_done) state <= ST_CLAMP;
                ST_CLAMP: begin
                    shadow_r <= (op_g == '0) ? GAIN_UNITY : gain_r_tmp;
                    shadow_b <= (op_g == '0) ? GAIN_UNITY : clamp_gain(div_quotient, op_b == '0);
                    state    <= ST_DONE;
                end
                ST_DONE: begin
                    pending <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: ;
            endcase

            if (commit && take_shadow) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gain_R      <= GAIN_UNITY;
            gain_B      <= GAIN_UNITY;
            gain_update <= 1'b0;
        end else begin
            gain_update <= 1'b0;
            if (commit) begin
                gain_R      <= next_r;
                gain_B      <= next_b;
                gain_update <= (next_r != gain_R) || (next_b != gain_B);
            end
        end
    end

endmodule
